// File: rtl/dsp_mac_sequencer.sv
// Streams signed (A,B) operand beats into one DSP48A1 slice used as a multiply-accumulate engine.
// Returns one 48-bit dot product per vector, together with its beat count and the slice CARRYOUT.
module dsp_mac_sequencer #(
    parameter int LAT     = 4,
    parameter int OPM_DLY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             s_valid_i,
    output logic             s_ready_o,
    input  logic [17:0]      s_a_i,
    input  logic [17:0]      s_b_i,
    input  logic             s_last_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [47:0]      m_data_o,
    output logic             m_carry_o,
    output logic [CNT_W-1:0] m_count_o,
    output logic             m_ovf_o,
    output logic [17:0]      dsp_a_o,
    output logic [17:0]      dsp_b_o,
    output logic [7:0]       dsp_opmode_o,
    output logic             dsp_ce_o,
    output logic             dsp_rst_o,
    input  logic [47:0]      dsp_p_i,
    input  logic             dsp_carryout_i
);

    typedef enum logic [1:0] {INIT, RUN, DRAIN, HOLD} state_t;

    localparam logic [7:0]       OPM_FIRST = 8'h01;
    localparam logic [7:0]       OPM_ACC   = 8'h09;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t                    state_q, state_d;
    logic [17:0]               a_q, b_q;
    logic [7:0]                opm_src_q;
    logic [OPM_DLY-1:0][7:0]   opm_q;
    logic [LAT:0]              tag_q;
    logic                      first_q;
    logic [CNT_W-1:0]          cnt_q;
    logic                      ovf_q;
    logic [47:0]               m_data_q;
    logic                      m_carry_q;
    logic [CNT_W-1:0]          m_count_q;
    logic                      m_ovf_q;
    logic                      accept;

    assign accept = s_valid_i && (state_q == RUN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            INIT:    state_d = RUN;
            RUN:     if (accept && s_last_i) state_d = DRAIN;
            DRAIN:   if (tag_q[LAT]) state_d = HOLD;
            HOLD:    if (m_ready_i) state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // The last tag travels alongside the operands, so it emerges exactly when the final sum sits on P.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q       <= '0;
            b_q       <= '0;
            opm_src_q <= OPM_ACC;
            opm_q     <= {OPM_DLY{OPM_ACC}};
            tag_q     <= '0;
            first_q   <= 1'b1;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            m_data_q  <= '0;
            m_carry_q <= 1'b0;
            m_count_q <= '0;
            m_ovf_q   <= 1'b0;
        end else begin
            a_q       <= accept ? s_a_i : 18'd0;
            b_q       <= accept ? s_b_i : 18'd0;
            opm_src_q <= (accept && first_q) ? OPM_FIRST : OPM_ACC;
            opm_q[0]  <= opm_src_q;
            for (int i = 1; i < OPM_DLY; i++) begin
                opm_q[i] <= opm_q[i-1];
            end
            tag_q <= {tag_q[LAT-1:0], accept && s_last_i};

            if (accept) begin
                first_q <= s_last_i;
                if (first_q) begin
                    cnt_q <= CNT_W'(1);
                    ovf_q <= 1'b0;
                end else if (cnt_q == CNT_MAX) begin
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            if (state_q == DRAIN && tag_q[LAT]) begin
                m_data_q  <= dsp_p_i;
                m_carry_q <= dsp_carryout_i;
                m_count_q <= cnt_q;
                m_ovf_q   <= ovf_q;
            end
        end
    end

    // CE follows reset release directly so the slice is enabled during the single INIT cycle.
    assign dsp_ce_o     = rst_ni;
    assign dsp_rst_o    = (state_q == INIT);
    assign s_ready_o    = (state_q == RUN);
    assign m_valid_o    = (state_q == HOLD);
    assign dsp_a_o      = a_q;
    assign dsp_b_o      = b_q;
    assign dsp_opmode_o = opm_q[OPM_DLY-1];
    assign m_data_o     = m_data_q;
    assign m_carry_o    = m_carry_q;
    assign m_count_o    = m_count_q;
    assign m_ovf_o      = m_ovf_q;

endmodule

// File: doc/dsp_mac_sequencer.md
Name: dsp_mac_sequencer

Overview:
- Stream-side controller that drives one DSP48A1 slice as a multiply-accumulate engine.
- Accepts (A,B) operand beats on a valid/ready input. Drives the slice's A/B/opmode/CE/RST ports and reads back P/CARRYOUT.
- Emits one 48-bit dot-product result per vector on a valid/ready output.
- The integrator ties the slice's D, C, BCIN and PCIN inputs to zero and CARRYIN to 0.

Parameters:
- LAT, 4, cycles from operands presented on dsp_a/dsp_b until the matching sum is visible on dsp_p. This matches the all-registers-enabled slice configuration.
- OPM_DLY, 2, cycles by which dsp_opmode is delayed relative to its operands so that the Z select reaches the post-adder together with its product.
- CNT_W, 16, width of the beat counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- s_valid  in  1  operand beat valid
- s_ready  out  1  operand beat accepted when s_valid and s_ready are both high
- s_a  in  18  multiplicand, two's complement
- s_b  in  18  multiplier, two's complement
- s_last  in  1  final beat of the vector
- m_valid  out  1  result valid
- m_ready  in  1  result accepted when m_valid and m_ready are both high
- m_data  out  48  accumulated sum
- m_carry  out  1  slice CARRYOUT captured with m_data
- m_count  out  CNT_W  number of beats in the vector, saturating
- m_ovf  out  1  beat count exceeded 2^CNT_W-1
- dsp_a  out  18  to slice A
- dsp_b  out  18  to slice B
- dsp_opmode  out  8  to slice OPMODE
- dsp_ce  out  1  to all slice CE inputs
- dsp_rst  out  1  to all slice RST inputs, active-high
- dsp_p  in  48  from slice P
- dsp_carryout  in  1  from slice CARRYOUT

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = INIT; s_ready = 0; m_valid = 0; m_data = 0; m_carry = 0; m_count = 0; m_ovf = 0.
  - dsp_a = 0, dsp_b = 0; dsp_opmode = 8'h09; dsp_ce = 0; dsp_rst = 1.
  - All tag/opmode delay lines are cleared.
- INIT:
  - Lasts one cycle after rst_n release.
  - dsp_rst = 1 and dsp_ce = 1 during INIT, then transition to RUN.
  - From RUN onward dsp_rst = 0 and dsp_ce = 1 permanently.
- RUN:
  - s_ready = 1.
  - On an accepted beat: dsp_a/dsp_b are registered from s_a/s_b (one cycle after the handshake).
  - Opmode source for an accepted beat: 8'h01 (X=M, Z=0) if it is the first beat of a vector, else 8'h09 (X=M, Z=P).
  - Bubble (no handshake): dsp_a = 0, dsp_b = 0, opmode source 8'h09, so P is unchanged.
  - The opmode source is delayed OPM_DLY cycles onto dsp_opmode.
  - First beat = first beat after INIT, or first beat after a vector's s_last.
  - Beat counter:
    - Reset to 1 on the first beat; incremented on each further beat.
    - Saturates at 2^CNT_W-1.
    - An increment attempted at saturation sets the vector's ovf flag.
  - Accepted beat with s_last = 1: go to DRAIN and push a last tag into a LAT-deep shift register.
- DRAIN:
  - s_ready = 0; bubbles are issued.
  - When the last tag emerges (LAT cycles after dsp_a/dsp_b carried the last beat):
    - capture m_data <= dsp_p, m_carry <= dsp_carryout, m_count, m_ovf;
    - m_valid <= 1; go to HOLD.
- HOLD:
  - s_ready = 0.
  - m_data, m_carry, m_count and m_ovf are stable while m_valid = 1.
  - On the m_valid && m_ready handshake: m_valid <= 0 and state = RUN.
  - s_ready rises the cycle after the handshake.
- Arithmetic:
  - Signed 18x18 product, sign-extended to 48 bits; accumulation is modulo 2^48.
  - m_carry reflects slice CARRYOUT unmodified.
- Boundary conditions:
  - A single-beat vector (first beat with s_last = 1) uses opmode 8'h01 and returns that product alone.
  - s_valid low between beats inserts bubbles and does not change the sum.
  - m_ready high at the same edge that m_valid rises does not complete a handshake; the handshake is sampled from the following edge.
  - rst_n low in any state aborts in-flight work. The pending result is discarded and m_valid drops immediately. The next vector after INIT is computed correctly.
- Throughput: one beat per cycle within a vector. Vector-to-vector gap is LAT + 2 cycles minimum.

Test Plan:
- Reset release, s_valid = 0 -> s_ready = 0 in INIT, dsp_rst = 1 for exactly one cycle, s_ready = 1 from the next cycle; m_valid stays 0.
- Vector (3,4),(5,6),(7,8), last on the third beat, m_ready = 1 -> m_data = 0x000000000062, m_count = 3, m_ovf = 0, m_carry = 0; m_valid high exactly one cycle.
- Same vector with s_valid low for 2 cycles between every beat -> m_data = 0x62, m_count = 3.
- Single beat (0x3FFFF, 2), last -> m_data = 0xFFFFFFFFFFFE. Next vector (2,3) -> m_data = 0x6, proving the Z=0 clear.
- Vector (10,20) with m_ready low for 5 cycles -> m_valid held, m_data = 0xC8 stable, s_ready = 0 throughout; s_ready = 1 the cycle after the handshake.
- rst_n pulsed low during DRAIN of vector (100,100) -> m_valid = 0 immediately and no result is emitted; then vector (1,1),(1,1) -> m_data = 0x2, m_count = 2.
